// File: rtl/uart_rx_cfg_if.sv
// Purpose: host-side bundle of the configurable UART receiver (serial line, word, handshake, flags).
// Latency: wiring only, no state.
// Backpressure: none; ready is held until the host pulses ready_clr, and unread words set overrun.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 ready_clr;
  logic                 ready;
  logic [DATA_BITS-1:0] data_out;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  // Host / line side: drives the serial line and the clear pulse, reads the result
  modport master (
    output rx, ready_clr,
    input  ready, data_out, parity_err, frame_err, overrun
  );

  // Receiver side
  modport slave (
    input  rx, ready_clr,
    output ready, data_out, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Purpose: oversampled UART receiver, configurable width/parity/stop bits, majority-vote sampling.
// Latency: word committed at the mid-bit decision point of the last stop bit (+2 cycles input sync).
// Backpressure: none; an uncleared word is overwritten and flagged with a sticky overrun.
module uart_rx_cfg #(
  parameter int CLOCKS_PER_PULSE = 16,
  parameter int DATA_BITS        = 8,
  parameter int PARITY_EN        = 0,
  parameter int PARITY_ODD       = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic          clk,
  input  logic          rstn,
  uart_rx_cfg_if.slave  bus
);

  localparam int CPP = CLOCKS_PER_PULSE;
  localparam int M   = CPP / 2;
  localparam int CW  = $clog2(CPP);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] C_SMP0 = CW'(M - 1);
  localparam logic [CW-1:0] C_SMP1 = CW'(M);
  localparam logic [CW-1:0] C_DEC  = CW'(M + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CPP - 1);
  localparam logic [BW-1:0] B_LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          ODD = 1'(PARITY_ODD);

  // BRK holds off re-arming after a frame whose final stop bit was low,
  // so a line held low reports one framing error instead of a stream of them.
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        c_clk, c_clk_n;
  logic [BW-1:0]        c_bit, c_bit_n;

  logic                 rx_m, rx_s;
  logic                 smp0, smp1;
  logic                 maj;
  logic                 is_dec, is_last;

  logic                 frame_start, do_shift, do_par, do_stop, do_commit;

  logic [DATA_BITS-1:0] word;
  logic                 perr_rec, ferr_rec;
  logic                 ferr_new;

  logic                 ready_q;
  logic [DATA_BITS-1:0] dout_q;
  logic                 perr_q, ferr_q, ovr_q;

  assign bus.ready      = ready_q;
  assign bus.data_out   = dout_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;

  // Two-flop synchroniser for the asynchronous line; idles high out of reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
    end
  end

  // Capture the two early samples; the third is rx_s itself at the decision cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      smp0 <= 1'b1;
      smp1 <= 1'b1;
    end else begin
      if (c_clk == C_SMP0) smp0 <= rx_s;
      if (c_clk == C_SMP1) smp1 <= rx_s;
    end
  end

  // Bit value is the 2-of-3 vote, only meaningful when c_clk is at the decision point
  always_comb begin
    maj     = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
    is_dec  = (c_clk == C_DEC);
    is_last = (c_clk == C_LAST);
  end

  // State, counters and per-cycle strobes for the datapath
  always_comb begin
    state_n     = state;
    c_clk_n     = c_clk;
    c_bit_n     = c_bit;
    frame_start = 1'b0;
    do_shift    = 1'b0;
    do_par      = 1'b0;
    do_stop     = 1'b0;
    do_commit   = 1'b0;

    if (state != IDLE && state != BRK) begin
      c_clk_n = is_last ? '0 : c_clk + 1'b1;
    end

    case (state)
      IDLE: begin
        // The falling-edge cycle itself is count 0
        if (!rx_s) begin
          state_n     = START;
          c_clk_n     = CW'(1);
          c_bit_n     = '0;
          frame_start = 1'b1;
        end
      end
      START: begin
        if (is_dec && maj) begin
          state_n = IDLE;
          c_clk_n = '0;
        end else if (is_last) begin
          state_n = DATA;
          c_bit_n = '0;
        end
      end
      DATA: begin
        if (is_dec) do_shift = 1'b1;
        if (is_last) begin
          if (c_bit == B_LAST_DATA) begin
            c_bit_n = '0;
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            c_bit_n = c_bit + 1'b1;
          end
        end
      end
      PARITY: begin
        if (is_dec) do_par = 1'b1;
        if (is_last) begin
          state_n = STOP;
          c_bit_n = '0;
        end
      end
      STOP: begin
        if (is_dec) do_stop = 1'b1;
        // Commit mid-bit so the next start edge is never missed
        if (is_dec && c_bit == B_LAST_STOP) begin
          do_commit = 1'b1;
          c_clk_n   = '0;
          c_bit_n   = '0;
          state_n   = maj ? IDLE : BRK;
        end else if (is_last) begin
          c_bit_n = c_bit + 1'b1;
        end
      end
      BRK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state and bit-timing counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      c_clk <= '0;
      c_bit <= '0;
    end else begin
      state <= state_n;
      c_clk <= c_clk_n;
      c_bit <= c_bit_n;
    end
  end

  // Assemble the word LSB first and record per-frame error conditions
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word     <= '0;
      perr_rec <= 1'b0;
      ferr_rec <= 1'b0;
    end else begin
      if (frame_start) begin
        perr_rec <= 1'b0;
        ferr_rec <= 1'b0;
      end
      if (do_shift) word <= {maj, word[DATA_BITS-1:1]};
      if (do_par) perr_rec <= maj ^ (^word) ^ ODD;
      if (do_stop && !maj) ferr_rec <= 1'b1;
    end
  end

  // The last stop bit's vote lands on the same edge as the commit
  always_comb begin
    ferr_new = ferr_rec | ~maj;
  end

  // Host-visible word and sticky flags; a commit outranks a simultaneous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_q <= 1'b0;
      dout_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (do_commit) begin
      ready_q <= 1'b1;
      dout_q  <= word;
      if (bus.ready_clr) begin
        perr_q <= perr_rec;
        ferr_q <= ferr_new;
        ovr_q  <= 1'b0;
      end else begin
        perr_q <= perr_q | perr_rec;
        ferr_q <= ferr_q | ferr_new;
        ovr_q  <= ovr_q | ready_q;
      end
    end else if (bus.ready_clr) begin
      ready_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Purpose: directed check of uart_rx_cfg in 8N1 and 8E1 builds.
// Latency: frames driven at 16 clocks per bit; results sampled on the falling edge.
// Backpressure: host clear pulses driven explicitly, including one aligned to a commit.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DATA_BITS(8)) b8 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) bp ();

  uart_rx_cfg #(.CLOCKS_PER_PULSE(16), .DATA_BITS(8), .PARITY_EN(0)) u_dut8 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b8)
  );

  uart_rx_cfg #(.CLOCKS_PER_PULSE(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dutp (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bp)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    bit         sel;      // 0 = 8N1 instance, 1 = 8E1 instance
    logic [7:0] data;
    logic       par;      // parity bit sent (8E1 only)
    logic       stop;
    bit         clr;      // pulse ready_clr before the frame
    bit         glitch;   // 1-cycle inversion at mid-bit of each data bit
    bit         chk_lat;
    logic [7:0] e_data;
    logic       e_perr;
    logic       e_ferr;
    logic       e_ovr;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [11:0] outs(input bit sel);
    if (sel) return {bp.data_out, bp.ready, bp.parity_err, bp.frame_err, bp.overrun};
    return {b8.data_out, b8.ready, b8.parity_err, b8.frame_err, b8.overrun};
  endfunction

  task automatic check_outs(input bit sel, input string tag, input logic [7:0] d,
                            input logic r, input logic pe, input logic fe, input logic ov);
    logic [11:0] o;
    o = outs(sel);
    check({tag, " data_out"},   o[11:4], d);
    check({tag, " ready"},      o[3],    r);
    check({tag, " parity_err"}, o[2],    pe);
    check({tag, " frame_err"},  o[1],    fe);
    check({tag, " overrun"},    o[0],    ov);
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) bp.rx = v; else b8.rx = v;
  endtask

  task automatic set_clr(input bit sel, input logic v);
    if (sel) bp.ready_clr = v; else b8.ready_clr = v;
  endtask

  task automatic pulse_clr(input bit sel, input string tag);
    logic [11:0] o;
    @(posedge clk); #1;
    set_clr(sel, 1'b1);
    @(posedge clk); #1;
    set_clr(sel, 1'b0);
    @(negedge clk);
    o = outs(sel);
    check({tag, " clr ready"},      o[3], 1'b0);
    check({tag, " clr parity_err"}, o[2], 1'b0);
    check({tag, " clr frame_err"},  o[1], 1'b0);
    check({tag, " clr overrun"},    o[0], 1'b0);
  endtask

  // Drives one frame, 16 cycles per bit. nb_lim truncates the frame (no idle tail).
  // clr_at raises ready_clr for one cycle at that global cycle index.
  // lat returns the first cycle index at which ready is seen high (-1 if never).
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic par,
                            input logic stop, input int nb_lim, input bit glitch,
                            input int clr_at, output int lat);
    logic [10:0] bits;
    logic [11:0] o;
    logic        v;
    int          nb;
    int          b;
    int          c;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (sel) begin
      bits[9]  = par;
      bits[10] = stop;
      nb = 11;
    end else begin
      bits[9] = stop;
      nb = 10;
    end
    if (nb_lim < nb) nb = nb_lim;
    lat = -1;
    for (int g = 0; g < nb * 16; g++) begin
      @(posedge clk); #1;
      b = g / 16;
      c = g % 16;
      v = bits[b];
      if (glitch && b >= 1 && b <= 8 && c == 8) v = ~v;
      set_rx(sel, v);
      set_clr(sel, (g == clr_at));
      o = outs(sel);
      if (lat < 0 && o[3]) lat = g;
    end
    if (nb_lim >= nb) begin
      for (int g = 0; g < 4; g++) begin
        @(posedge clk); #1;
        set_rx(sel, 1'b1);
        set_clr(sel, 1'b0);
        o = outs(sel);
        if (lat < 0 && o[3]) lat = nb * 16 + g;
      end
    end
  endtask

  initial begin
    int lat;
    string tag;

    //           sel data   par stop clr glt lat  e_data perr ferr ovr
    vecs[0] = '{1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 1'b1};

    b8.rx = 1'b1; b8.ready_clr = 1'b0;
    bp.rx = 1'b1; bp.ready_clr = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outs(1'b0, "reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset 8E1 ready", bp.ready, 1'b0);
    rstn = 1'b1;
    repeat (5) @(posedge clk);

    // False start: 4 low cycles, rejected at the first mid-bit vote
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      b8.rx = 1'b0;
    end
    @(posedge clk); #1;
    b8.rx = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("false start ready", b8.ready, 1'b0);
    check("false start data_out", b8.data_out, 8'h00);

    // Table-driven frames
    for (int i = 0; i < 10; i++) begin
      tag = $sformatf("vec%0d", i);
      if (vecs[i].clr) pulse_clr(vecs[i].sel, tag);
      send_frame(vecs[i].sel, vecs[i].data, vecs[i].par, vecs[i].stop, 99,
                 vecs[i].glitch, -1, lat);
      @(negedge clk);
      check_outs(vecs[i].sel, tag, vecs[i].e_data, 1'b1,
                 vecs[i].e_perr, vecs[i].e_ferr, vecs[i].e_ovr);
      if (vecs[i].chk_lat) begin
        if (!(lat >= 146 && lat <= 164))
          $display("  %s ready latency %0d cycles", tag, lat);
        check({tag, " ready latency in 146..164"}, (lat >= 146 && lat <= 164), 1'b1);
      end
    end

    // ready_clr on the exact commit edge of a frame arriving while overrun is set:
    // commit wins, overrun is not re-set. Commit edge is the one after cycle index 155.
    send_frame(1'b0, 8'h33, 1'b0, 1'b1, 99, 1'b0, 155, lat);
    @(negedge clk);
    check_outs(1'b0, "clr at commit", 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a frame
    send_frame(1'b0, 8'h81, 1'b0, 1'b1, 5, 1'b0, -1, lat);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    check_outs(1'b0, "mid-frame reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    b8.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("after reset release ready", b8.ready, 1'b0);
    check("after reset release frame_err", b8.frame_err, 1'b0);
    check("after reset release data_out", b8.data_out, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
